// File: rtl/gen_stream_pkg.sv
// gen_stream_pkg: shared constants and FSM state type for the stream collector.
package gen_stream_pkg;
  localparam int DATA_W = 32;
  localparam int DEPTH_DEF = 8;
  localparam int CNT_W_DEF = 8;
  typedef enum logic [1:0] {IDLE, LAUNCH, COLLECT, DRAIN} state_t;
endpackage

// File: rtl/gen_stream_fifo.sv
// gen_stream_fifo: show-ahead FIFO with synchronous flush; head reads 0 when empty.
module gen_stream_fifo import gen_stream_pkg::*; #(
  parameter int DEPTH = DEPTH_DEF,
  parameter int W = DATA_W
) (
  input  logic         _clock,
  input  logic         _reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wr, rd;
  logic do_push, do_pop;
  // Extra pointer bit separates full from empty when the indices match.
  assign empty = wr == rd;
  assign full = (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
  assign do_push = push && !full && !flush;
  assign do_pop = pop && !empty && !flush;
  assign head = empty ? '0 : mem[rd[AW-1:0]];
  always_ff @(posedge _clock or posedge _reset) begin
    if (_reset) begin
      wr <= '0;
      rd <= '0;
    end else if (flush) begin
      wr <= '0;
      rd <= '0;
    end else begin
      if (do_push) wr <= wr + 1'b1;
      if (do_pop) rd <= rd + 1'b1;
    end
  end
  always_ff @(posedge _clock) begin
    if (do_push) mem[wr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/gen_stream_collector.sv
// gen_stream_collector: launches a value generator, buffers its stream in a FIFO
// and tracks the item count and running sum of each run.
module gen_stream_collector import gen_stream_pkg::*; #(
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                     _clock,
  input  logic                     _reset,
  input  logic                     _start,
  input  logic signed [DATA_W-1:0] base,
  input  logic signed [DATA_W-1:0] limit,
  input  logic signed [DATA_W-1:0] step,
  output logic                     _gen_start,
  output logic signed [DATA_W-1:0] _gen_base,
  output logic signed [DATA_W-1:0] _gen_limit,
  output logic signed [DATA_W-1:0] _gen_step,
  output logic                     _gen_ready,
  input  logic                     _gen_valid,
  input  logic                     _gen_done,
  input  logic signed [DATA_W-1:0] _gen_0,
  input  logic                     _pop,
  output logic                     _out_valid,
  output logic signed [DATA_W-1:0] _out_data,
  output logic [CNT_W-1:0]         _count,
  output logic signed [DATA_W-1:0] _sum,
  output logic                     _busy,
  output logic                     _done
);
  state_t state;
  logic full, empty, xfer;
  logic [DATA_W-1:0] head;
  assign _gen_ready = (state == COLLECT) && !full;
  assign xfer = _gen_valid && _gen_ready;
  assign _gen_start = state == LAUNCH;
  assign _busy = state != IDLE;
  assign _done = (state == DRAIN) && empty;
  assign _out_valid = !empty;
  assign _out_data = head;
  gen_stream_fifo #(.DEPTH(DEPTH), .W(DATA_W)) fifo (
    ._clock(_clock),
    ._reset(_reset),
    .push(xfer),
    .pop(_pop),
    .flush(_start),
    .din(_gen_0),
    .full(full),
    .empty(empty),
    .head(head)
  );
  // A new start restarts from any state, discarding the current run.
  always_ff @(posedge _clock or posedge _reset) begin
    if (_reset) begin
      state <= IDLE;
      _gen_base <= '0;
      _gen_limit <= '0;
      _gen_step <= '0;
      _count <= '0;
      _sum <= '0;
    end else if (_start) begin
      state <= LAUNCH;
      _gen_base <= base;
      _gen_limit <= limit;
      _gen_step <= step;
      _count <= '0;
      _sum <= '0;
    end else begin
      if (xfer) begin
        _count <= &_count ? _count : _count + 1'b1;
        _sum <= _sum + _gen_0;
      end
      state <= state == LAUNCH ? COLLECT :
               (state == COLLECT && _gen_done) ? DRAIN :
               (state == DRAIN && empty) ? IDLE : state;
    end
  end
endmodule

// File: tb/tb_gen_stream_collector.sv
// tb_gen_stream_collector: directed runs against a behavioural range/list generator.
module tb_gen_stream_collector;
  logic clk = 0, rst = 1, start = 0, pop = 0;
  logic signed [31:0] base = 0, limit = 0, step = 0;
  logic gen_start, gen_ready, gen_valid, gen_done, out_valid, busy, done;
  logic signed [31:0] gen_base, gen_limit, gen_step, gen_0, out_data, sum;
  logic [7:0] count;
  int n_vec = 0, n_bad = 0;
  int done_cnt = 0, vcnt = 0;
  logic [31:0] q[$];
  logic g_act, list_mode = 0;
  logic signed [31:0] g_cur, g_lim, g_step;
  int g_idx;
  logic [31:0] lst [2];

  always #5 clk = ~clk;

  gen_stream_collector dut (
    ._clock(clk), ._reset(rst), ._start(start),
    .base(base), .limit(limit), .step(step),
    ._gen_start(gen_start), ._gen_base(gen_base), ._gen_limit(gen_limit), ._gen_step(gen_step),
    ._gen_ready(gen_ready), ._gen_valid(gen_valid), ._gen_done(gen_done), ._gen_0(gen_0),
    ._pop(pop), ._out_valid(out_valid), ._out_data(out_data),
    ._count(count), ._sum(sum), ._busy(busy), ._done(done)
  );

  always @(posedge clk or posedge rst) begin
    if (rst) g_act <= 0;
    else if (gen_start) begin
      g_act <= 1;
      g_cur <= gen_base;
      g_lim <= gen_limit;
      g_step <= gen_step;
      g_idx <= 0;
    end else if (gen_valid && gen_ready) begin
      g_cur <= g_cur + g_step;
      g_idx <= g_idx + 1;
    end
  end
  assign gen_valid = g_act && (list_mode ? g_idx < 2 : g_cur < g_lim);
  assign gen_done = g_act && !gen_valid;
  assign gen_0 = list_mode ? lst[g_idx[0]] : g_cur;

  always @(posedge clk) begin
    if (pop && out_valid) q.push_back(out_data);
    if (done) done_cnt <= done_cnt + 1;
    if (out_valid) vcnt <= vcnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic signed [31:0] b, input logic signed [31:0] l, input logic signed [31:0] s);
    base = b; limit = l; step = s; start = 1;
    tick();
    start = 0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0 = done_cnt;
    int i = 0;
    while (done_cnt == d0 && i < budget) begin
      tick();
      i++;
    end
    tick(3);
    chk(tag, done_cnt - d0, 1);
  endtask

  task automatic chk_q(input string tag, input int qb, input int b, input int s, input int n);
    chk({tag, "_n"}, q.size() - qb, n);
    for (int i = 0; i < n && qb + i < q.size(); i++) chk({tag, "_d"}, q[qb + i], b + i * s);
  endtask

  initial begin
    int qb, v0, d0;
    lst[0] = 32'h7fffffff;
    lst[1] = 32'h1;
    tick(2);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_count", count, 0);
    chk("rst_sum", sum, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_gstart", gen_start, 0);
    chk("rst_gready", gen_ready, 0);
    chk("rst_gbase", gen_base, 0);
    rst = 0;
    tick();
    // Range (0,10,2) with pop held high
    qb = q.size();
    pop = 1;
    start_run(0, 10, 2);
    chk("t1_gstart", gen_start, 1);
    chk("t1_glimit", gen_limit, 10);
    chk("t1_gstep", gen_step, 2);
    chk("t1_busy", busy, 1);
    tick();
    chk("t1_gstart_off", gen_start, 0);
    chk("t1_ready", gen_ready, 1);
    chk("t1_lat0", out_valid, 0);
    tick();
    chk("t1_lat1", out_valid, 1);
    chk("t1_first", out_data, 0);
    wait_done("t1_done", 100);
    chk_q("t1", qb, 0, 2, 5);
    chk("t1_count", count, 5);
    chk("t1_sum", sum, 20);
    chk("t1_idle", busy, 0);
    // Range (0,12,1) fills FIFO before popping
    qb = q.size();
    pop = 0;
    start_run(0, 12, 1);
    tick(16);
    chk("t2_ready", gen_ready, 0);
    chk("t2_count", count, 8);
    chk("t2_head", out_data, 0);
    pop = 1;
    wait_done("t2_done", 100);
    chk_q("t2", qb, 0, 1, 12);
    chk("t2_sum", sum, 66);
    // Empty range
    qb = q.size();
    v0 = vcnt;
    start_run(5, 5, 1);
    wait_done("t3_done", 50);
    chk("t3_valid", vcnt - v0, 0);
    chk("t3_count", count, 0);
    chk("t3_sum", sum, 0);
    // Restart during COLLECT
    pop = 0;
    start_run(0, 100, 1);
    tick(5);
    chk("t4_pre", count, 4);
    start_run(3, 9, 3);
    chk("t4_flush", out_valid, 0);
    chk("t4_clr", count, 0);
    chk("t4_base", gen_base, 3);
    qb = q.size();
    pop = 1;
    wait_done("t4_done", 100);
    chk_q("t4", qb, 3, 3, 2);
    chk("t4_count", count, 2);
    chk("t4_sum", sum, 9);
    // Asynchronous reset mid-COLLECT
    pop = 0;
    start_run(0, 100, 1);
    tick(4);
    chk("t5_pre", count, 3);
    d0 = done_cnt;
    #2 rst = 1;
    #1;
    chk("t5_count", count, 0);
    chk("t5_valid", out_valid, 0);
    chk("t5_sum", sum, 0);
    chk("t5_busy", busy, 0);
    chk("t5_ready", gen_ready, 0);
    chk("t5_gbase", gen_base, 0);
    #1 rst = 0;
    tick(3);
    chk("t5_nodone", done_cnt - d0, 0);
    chk("t5_idle", busy, 0);
    qb = q.size();
    pop = 1;
    start_run(0, 4, 1);
    wait_done("t5_done", 100);
    chk_q("t5", qb, 0, 1, 4);
    chk("t5_sum2", sum, 6);
    // Reset and start together
    rst = 1;
    start_run(7, 20, 1);
    chk("t6_busy", busy, 0);
    chk("t6_gbase", gen_base, 0);
    rst = 0;
    tick();
    // Sum wrap
    list_mode = 1;
    qb = q.size();
    start_run(0, 0, 0);
    wait_done("t7_done", 50);
    chk("t7_sum", sum, 32'h80000000);
    chk("t7_count", count, 2);
    chk("t7_n", q.size() - qb, 2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
